// File: rtl/fxu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : fxu_reservation_station
// Brief    : Reservation station for one fixed-point unit. It accepts
//            dispatched operations, snoops the ROB result broadcast for
//            missing operands, and issues the lowest-index ready entry
//            through a registered valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fxu_reservation_station #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [3:0]  in_opcode,
    input  logic [3:0]  in_rob_tag,
    input  logic        in_a_valid,
    input  logic [15:0] in_a_value,
    input  logic [3:0]  in_a_owner,
    input  logic        in_b_valid,
    input  logic [15:0] in_b_value,
    input  logic [3:0]  in_b_owner,
    output logic        full,
    input  logic        rob_output_valid  [0:15],
    input  logic [15:0] rob_output_values [0:15],
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [3:0]  issue_opcode,
    output logic [3:0]  issue_rob_tag,
    output logic [15:0] issue_a,
    output logic [15:0] issue_b
);

    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic [DEPTH-1:0] r_busy;
    logic [3:0]       r_opcode [DEPTH];
    logic [3:0]       r_tag    [DEPTH];
    logic             r_a_rdy  [DEPTH];
    logic [15:0]      r_a_val  [DEPTH];
    logic [3:0]       r_a_own  [DEPTH];
    logic             r_b_rdy  [DEPTH];
    logic [15:0]      r_b_val  [DEPTH];
    logic [3:0]       r_b_own  [DEPTH];

    // Issue register
    logic        r_issue_valid;
    logic [3:0]  r_issue_opcode;
    logic [3:0]  r_issue_tag;
    logic [15:0] r_issue_a;
    logic [15:0] r_issue_b;

    logic            w_alloc;
    logic            w_move;
    logic            w_any_cand;
    logic [c_IW-1:0] w_sel_idx;
    logic [c_IW-1:0] w_alloc_idx;
    logic            w_a_rdy_in;
    logic [15:0]     w_a_val_in;
    logic            w_b_rdy_in;
    logic [15:0]     w_b_val_in;

    assign full    = &r_busy;
    assign w_alloc = in_valid & ~full;
    assign w_move  = w_any_cand & (~r_issue_valid | issue_ready);

    // A result broadcast in the dispatch cycle is forwarded straight into the new entry
    assign w_a_rdy_in = in_a_valid | rob_output_valid[in_a_owner];
    assign w_a_val_in = in_a_valid ? in_a_value : rob_output_values[in_a_owner];
    assign w_b_rdy_in = in_b_valid | rob_output_valid[in_b_owner];
    assign w_b_val_in = in_b_valid ? in_b_value : rob_output_values[in_b_owner];

    // Lowest-index ready candidate and lowest-index free slot, from registered state
    always_comb begin
        w_any_cand  = 1'b0;
        w_sel_idx   = '0;
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i = i - 1) begin
            if (r_busy[i] && r_a_rdy[i] && r_b_rdy[i]) begin
                w_any_cand = 1'b1;
                w_sel_idx  = c_IW'(i);
            end
            if (!r_busy[i]) begin
                w_alloc_idx = c_IW'(i);
            end
        end
    end

    // Entry update: free on move, write on allocation, otherwise snoop for wakeup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_opcode[i] <= '0;
                r_tag[i]    <= '0;
                r_a_rdy[i]  <= 1'b0;
                r_a_val[i]  <= '0;
                r_a_own[i]  <= '0;
                r_b_rdy[i]  <= 1'b0;
                r_b_val[i]  <= '0;
                r_b_own[i]  <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_move && (w_sel_idx == c_IW'(i))) begin
                    r_busy[i] <= 1'b0;
                end else if (w_alloc && (w_alloc_idx == c_IW'(i))) begin
                    r_busy[i]   <= 1'b1;
                    r_opcode[i] <= in_opcode;
                    r_tag[i]    <= in_rob_tag;
                    r_a_rdy[i]  <= w_a_rdy_in;
                    r_a_val[i]  <= w_a_val_in;
                    r_a_own[i]  <= in_a_owner;
                    r_b_rdy[i]  <= w_b_rdy_in;
                    r_b_val[i]  <= w_b_val_in;
                    r_b_own[i]  <= in_b_owner;
                end else if (r_busy[i]) begin
                    if (!r_a_rdy[i] && rob_output_valid[r_a_own[i]]) begin
                        r_a_rdy[i] <= 1'b1;
                        r_a_val[i] <= rob_output_values[r_a_own[i]];
                    end
                    if (!r_b_rdy[i] && rob_output_valid[r_b_own[i]]) begin
                        r_b_rdy[i] <= 1'b1;
                        r_b_val[i] <= rob_output_values[r_b_own[i]];
                    end
                end
            end
        end
    end

    // Issue register: load the winner when free or being accepted, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid  <= 1'b0;
            r_issue_opcode <= '0;
            r_issue_tag    <= '0;
            r_issue_a      <= '0;
            r_issue_b      <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_move) begin
            r_issue_valid  <= 1'b1;
            r_issue_opcode <= r_opcode[w_sel_idx];
            r_issue_tag    <= r_tag[w_sel_idx];
            r_issue_a      <= r_a_val[w_sel_idx];
            r_issue_b      <= r_b_val[w_sel_idx];
        end else if (issue_ready) begin
            r_issue_valid <= 1'b0;
        end
    end

    assign issue_valid   = r_issue_valid;
    assign issue_opcode  = r_issue_opcode;
    assign issue_rob_tag = r_issue_tag;
    assign issue_a       = r_issue_a;
    assign issue_b       = r_issue_b;

endmodule
`default_nettype wire

// File: tb/tb_fxu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxu_reservation_station
// Brief    : Directed self-checking bench for fxu_reservation_station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxu_reservation_station;

    localparam int c_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_opcode;
    logic [3:0]  in_rob_tag;
    logic        in_a_valid;
    logic [15:0] in_a_value;
    logic [3:0]  in_a_owner;
    logic        in_b_valid;
    logic [15:0] in_b_value;
    logic [3:0]  in_b_owner;
    logic        full;
    logic        rob_output_valid  [0:15];
    logic [15:0] rob_output_values [0:15];
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_opcode;
    logic [3:0]  issue_rob_tag;
    logic [15:0] issue_a;
    logic [15:0] issue_b;

    int checks;
    int failures;

    fxu_reservation_station #(.DEPTH(c_DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_opcode         (in_opcode),
        .in_rob_tag        (in_rob_tag),
        .in_a_valid        (in_a_valid),
        .in_a_value        (in_a_value),
        .in_a_owner        (in_a_owner),
        .in_b_valid        (in_b_valid),
        .in_b_value        (in_b_value),
        .in_b_owner        (in_b_owner),
        .full              (full),
        .rob_output_valid  (rob_output_valid),
        .rob_output_values (rob_output_values),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_opcode      (issue_opcode),
        .issue_rob_tag     (issue_rob_tag),
        .issue_a           (issue_a),
        .issue_b           (issue_b)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one dispatch for a single edge
    task automatic dispatch(input logic [3:0] op, input logic [3:0] tag,
                            input logic av, input logic [15:0] aval, input logic [3:0] aown,
                            input logic bv, input logic [15:0] bval, input logic [3:0] bown);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rob_tag = tag;
        in_a_valid = av;
        in_a_value = aval;
        in_a_owner = aown;
        in_b_valid = bv;
        in_b_value = bval;
        in_b_owner = bown;
        step();
        in_valid   = 1'b0;
    endtask

    initial begin
        logic [3:0] order [4];
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_opcode   = '0;
        in_rob_tag  = '0;
        in_a_valid  = 1'b0;
        in_a_value  = '0;
        in_a_owner  = '0;
        in_b_valid  = 1'b0;
        in_b_value  = '0;
        in_b_owner  = '0;
        issue_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rob_output_valid[i]  = 1'b0;
            rob_output_values[i] = '0;
        end

        // Reset state
        step();
        check("rst_valid", {31'd0, issue_valid}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        rst_n = 1'b1;
        step();

        // Simple issue: two edges from dispatch to issue_valid
        dispatch(4'd3, 4'd5, 1'b1, 16'h0010, 4'd0, 1'b1, 16'h0020, 4'd0);
        check("simple_not_yet", {31'd0, issue_valid}, 32'd0);
        step();
        check("simple_valid", {31'd0, issue_valid}, 32'd1);
        check("simple_op", {28'd0, issue_opcode}, 32'd3);
        check("simple_tag", {28'd0, issue_rob_tag}, 32'd5);
        check("simple_a", {16'd0, issue_a}, 32'h0010);
        check("simple_b", {16'd0, issue_b}, 32'h0020);
        step();
        check("simple_drain", {31'd0, issue_valid}, 32'd0);

        // Wakeup: A waits on ROB 7
        dispatch(4'd1, 4'd6, 1'b0, 16'h0000, 4'd7, 1'b1, 16'h0055, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("wake_wait", {31'd0, issue_valid}, 32'd0);
            step();
        end
        rob_output_valid[7]  = 1'b1;
        rob_output_values[7] = 16'hBEEF;
        step();
        rob_output_valid[7]  = 1'b0;
        check("wake_capture_edge", {31'd0, issue_valid}, 32'd0);
        step();
        check("wake_valid", {31'd0, issue_valid}, 32'd1);
        check("wake_a", {16'd0, issue_a}, 32'hBEEF);
        check("wake_b", {16'd0, issue_b}, 32'h0055);
        check("wake_tag", {28'd0, issue_rob_tag}, 32'd6);
        step();
        check("wake_drain", {31'd0, issue_valid}, 32'd0);

        // Same-cycle forward from ROB 2
        rob_output_valid[2]  = 1'b1;
        rob_output_values[2] = 16'h1234;
        dispatch(4'd2, 4'd9, 1'b0, 16'h0000, 4'd2, 1'b1, 16'h0001, 4'd0);
        rob_output_valid[2]  = 1'b0;
        check("fwd_not_yet", {31'd0, issue_valid}, 32'd0);
        step();
        check("fwd_valid", {31'd0, issue_valid}, 32'd1);
        check("fwd_a", {16'd0, issue_a}, 32'h1234);
        step();
        check("fwd_drain", {31'd0, issue_valid}, 32'd0);

        // Full and backpressure: tags 0..4 with issue_ready low
        issue_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            dispatch(4'd4, 4'(t), 1'b1, 16'h0100 + 16'(t), 4'd0, 1'b1, 16'h0200 + 16'(t), 4'd0);
            check("bp_full", {31'd0, full}, (t == 4) ? 32'd1 : 32'd0);
        end
        // Held output with further dispatches refused while full
        for (int i = 0; i < 5; i++) begin
            check("held_valid", {31'd0, issue_valid}, 32'd1);
            check("held_tag", {28'd0, issue_rob_tag}, 32'd0);
            check("held_a", {16'd0, issue_a}, 32'h0100);
            check("held_full", {31'd0, full}, 32'd1);
            step();
        end
        // Slots: e0=tag2, e1=tag1, e2=tag3, e3=tag4
        order[0] = 4'd2;
        order[1] = 4'd1;
        order[2] = 4'd3;
        order[3] = 4'd4;
        issue_ready = 1'b1;
        step();
        check("bp_full_drop", {31'd0, full}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("bp_order_valid", {31'd0, issue_valid}, 32'd1);
            check("bp_order_tag", {28'd0, issue_rob_tag}, {28'd0, order[i]});
            check("bp_order_b", {16'd0, issue_b}, 32'h0200 + {28'd0, order[i]});
            step();
        end
        check("bp_drain", {31'd0, issue_valid}, 32'd0);

        // Flush with 3 busy entries and a held issue
        issue_ready = 1'b0;
        for (int t = 8; t < 12; t++) begin
            dispatch(4'd5, 4'(t), 1'b1, 16'(t), 4'd0, 1'b1, 16'(t), 4'd0);
        end
        check("pre_flush_valid", {31'd0, issue_valid}, 32'd1);
        check("pre_flush_full", {31'd0, full}, 32'd0);
        flush       = 1'b1;
        issue_ready = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", {31'd0, issue_valid}, 32'd0);
        check("flush_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_flush_idle", {31'd0, issue_valid}, 32'd0);
        end

        // Asynchronous reset between edges while full and issuing
        issue_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            dispatch(4'hF, 4'hA, 1'b1, 16'hAAAA, 4'd0, 1'b1, 16'h5555, 4'd0);
        end
        check("pre_rst_full", {31'd0, full}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, issue_valid}, 32'd0);
        check("arst_full", {31'd0, full}, 32'd0);
        check("arst_op", {28'd0, issue_opcode}, 32'd0);
        check("arst_tag", {28'd0, issue_rob_tag}, 32'd0);
        check("arst_a", {16'd0, issue_a}, 32'd0);
        check("arst_b", {16'd0, issue_b}, 32'd0);
        #1;
        rst_n = 1'b1;
        issue_ready = 1'b1;
        step();
        step();
        check("post_rst_idle", {31'd0, issue_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fxu_reservation_station.md
# fxu_reservation_station

Reservation station for one fixed-point unit. It sits on the receiving end of the instruction buffer's per-FXU dispatch port and reports `full` back to it. Each entry holds one operation and snoops the ROB result broadcast until both operands are present. It then issues one ready operation per cycle to the FXU execute stage through a registered valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4: number of station entries (2..8).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous; discards all entries and the issue register.
- `in_valid`  in  1  dispatch strobe from the instruction buffer.
- `in_opcode`  in  4  operation code.
- `in_rob_tag`  in  4  ROB entry that receives this result.
- `in_a_valid`  in  1  operand A value is present.
- `in_a_value`  in  16  operand A value.
- `in_a_owner`  in  4  ROB tag producing A.
- `in_b_valid`, `in_b_value`, `in_b_owner`  in  1/16/4  same fields for operand B.
- `full`  out  1  no free entry; the dispatcher must not assert `in_valid`.
- `rob_output_valid[0:15]`  in  1 each  ROB entry result valid.
- `rob_output_values[0:15]`  in  16 each  ROB entry result values.
- `issue_valid`  out  1  issue register holds an operation.
- `issue_ready`  in  1  execute stage accepts.
- `issue_opcode`  out  4  issued opcode.
- `issue_rob_tag`  out  4  issued ROB tag.
- `issue_a`, `issue_b`  out  16 each  issued operand values.

## Operation
- Per-entry state: `busy`, `opcode`, `rob_tag`, and for each operand a `rdy` bit, a 16-bit value and a 4-bit owner.
- Allocation:
  - When `in_valid & ~full`, the operation is written into the lowest-index entry with `busy=0`.
  - `in_valid` while `full` is a protocol violation. The input is dropped and state is unchanged.
- Operand capture at allocation:
  - If `in_x_valid=1`, store `rdy=1` with `in_x_value`.
  - Otherwise, if `rob_output_valid[in_x_owner]=1` in the same cycle, store `rdy=1` with `rob_output_values[in_x_owner]`.
  - Otherwise store `rdy=0` and the owner.
- Wakeup: every cycle, each busy entry with an operand at `rdy=0` and `rob_output_valid[owner]=1` sets `rdy=1` and latches the ROB value. The values are 16 bits wide with no transformation.
- Select:
  - Candidates are entries with `busy & a_rdy & b_rdy`, using registered bits only. A wakeup or allocation in cycle N makes an entry eligible in cycle N+1.
  - The lowest-index candidate wins.
- Move:
  - Happens when a candidate exists and the issue register is free: `~issue_valid`, or `issue_valid & issue_ready` this cycle.
  - On the edge, the winner's fields load the issue register, `issue_valid=1`, and the entry is cleared to `busy=0`.
  - When a move happens while an accept is in flight, `issue_valid` stays 1 and the new contents are presented.
- Issue register: contents are held stable while `issue_valid & ~issue_ready`. After an accept with no move, `issue_valid=0`.
- `full`: combinational AND of all `busy` bits, driven from registered state only. The issue register does not count toward `full`.
- Allocation and free in the same cycle: allocation sees the start-of-cycle `busy` bits, so the freed slot is usable the following cycle.
- `flush`:
  - Clears all `busy` bits and sets `issue_valid=0`.
  - Takes priority over allocation, wakeup and move in the same cycle.
  - The `issue_ready` handshake of that cycle is ignored.

## Timing
- Reset values (asynchronous, `rst_n=0`): all `busy=0`, `issue_valid=0`, `issue_opcode=0`, `issue_rob_tag=0`, `issue_a=0`, `issue_b=0`, `full=0`.
- Reset mid-operation discards everything immediately, without waiting for a clock edge.
- Dispatch-to-issue latency:
  - Dispatch sampled at edge E0 with both operands present gives `issue_valid=1` after edge E1 (2 edges), provided the issue register is free.
  - An operand woken by the broadcast sampled at edge Ew issues after Ew+1 at the earliest.
- Throughput: at most one allocation and one issue per cycle. Back-to-back issue is sustained while `issue_ready=1`.
- `full` rises in the cycle after the allocation that fills the last entry. It falls in the cycle after the move that frees any entry.

## Test plan
- Simple issue: dispatch opcode 3, tag 5, A=0x0010, B=0x0020, both valid. `issue_valid=1` two edges later with `issue_a=0x0010`, `issue_b=0x0020`, `issue_rob_tag=5`.
- Wakeup:
  - Dispatch with A waiting on owner 7; hold `issue_ready=1`.
  - No issue until `rob_output_valid[7]=1` with value 0xBEEF.
  - Issue follows one edge after capture with `issue_a=0xBEEF`.
- Same-cycle forward: dispatch with A not valid, owner 2, while `rob_output_valid[2]=1` with value 0x1234. The entry is ready on allocation and issues two edges later with `issue_a=0x1234`.
- Full and backpressure:
  - Hold `issue_ready=0` and dispatch DEPTH+1 ready ops with tags 0..4.
  - One op moves to the issue register, so `full=1` only after the fifth dispatch.
  - Release `issue_ready`; tags issue in lowest-index order and `full` drops one cycle after the first move.
- Held output: while `issue_ready=0`, `issue_*` remains constant for 5 cycles despite new ready entries arriving.
- Flush and reset:
  - Assert `flush` with 3 busy entries and `issue_valid=1`; next cycle `issue_valid=0`, `full=0`, and no issue occurs afterwards.
  - Pulse `rst_n=0` between clock edges; all outputs are 0 immediately.
